// File: rtl/wisc_ctrl_pkg.sv
// Shared types and constants for the WISC fetch sequencing controller.
package wisc_ctrl_pkg;

   localparam int DEFAULT_ADDR_W = 16;
   localparam int DRAIN_CNT_W    = 4;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      WAIT_MEM = 2'd1,
      DRAIN    = 2'd2,
      HALTED   = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// PC sequencing controller: arbitrates branch/jump redirects, holds a redirect
// across instruction-memory wait states, and drains the pipe on HLT.
module fetch_ctrl
   import wisc_ctrl_pkg::*;
#(
   parameter int ADDR_W       = DEFAULT_ADDR_W,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              imem_rdy,
   input  logic              ld_use_stall,
   input  logic              id_jmp,
   input  logic [ADDR_W-1:0] id_jmp_addr,
   input  logic              ex_br_taken,
   input  logic [ADDR_W-1:0] ex_br_addr,
   input  logic              id_hlt,
   output logic              pc_hold,
   output logic              pc_take_branch,
   output logic [ADDR_W-1:0] pc_br_addr,
   output logic              pc_take_jump,
   output logic [ADDR_W-1:0] pc_jmp_addr,
   output logic              stall_ifid,
   output logic              flush_ifid,
   output logic              flush_idex,
   output logic              halted
);

   localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

   fetch_state_e             state_q, state_d;
   logic                     pend_valid_q, pend_valid_d;
   logic [ADDR_W-1:0]        pend_addr_q, pend_addr_d;
   logic [DRAIN_CNT_W-1:0]   drain_cnt_q, drain_cnt_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= RUN;
         pend_valid_q <= 1'b0;
         pend_addr_q  <= '0;
         drain_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         drain_cnt_q  <= drain_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pend_valid_d = pend_valid_q;
      pend_addr_d  = pend_addr_q;
      drain_cnt_d  = drain_cnt_q;
      unique case (state_q)
         RUN: begin
            if (ex_br_taken) begin
               if (!imem_rdy) begin
                  pend_addr_d  = ex_br_addr;
                  pend_valid_d = 1'b1;
                  state_d      = WAIT_MEM;
               end
            end else if (ld_use_stall) begin
               state_d = RUN;
            end else if (id_jmp) begin
               if (!imem_rdy) begin
                  pend_addr_d  = id_jmp_addr;
                  pend_valid_d = 1'b1;
                  state_d      = WAIT_MEM;
               end
            end else if (id_hlt) begin
               drain_cnt_d = DRAIN_LOAD;
               state_d     = DRAIN;
            end
         end
         WAIT_MEM: begin
            if (imem_rdy) begin
               pend_valid_d = 1'b0;
               state_d      = RUN;
            end else if (ex_br_taken) begin
               pend_addr_d  = ex_br_addr;
               pend_valid_d = 1'b1;
            end
         end
         DRAIN: begin
            if (drain_cnt_q == '0) begin
               state_d = HALTED;
            end else begin
               drain_cnt_d = drain_cnt_q - 1'b1;
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // Outputs are combinational on the current inputs so a redirect reaches the PC in the same cycle.
   always_comb begin
      pc_hold        = 1'b0;
      pc_take_branch = 1'b0;
      pc_br_addr     = '0;
      pc_take_jump   = 1'b0;
      pc_jmp_addr    = '0;
      stall_ifid     = 1'b0;
      flush_ifid     = 1'b0;
      flush_idex     = 1'b0;
      halted         = 1'b0;
      if (!rst_n) begin
         pc_hold = 1'b1;
      end else begin
         unique case (state_q)
            RUN: begin
               if (ex_br_taken) begin
                  flush_ifid = 1'b1;
                  flush_idex = 1'b1;
                  if (imem_rdy) begin
                     pc_take_branch = 1'b1;
                     pc_br_addr     = ex_br_addr;
                  end else begin
                     pc_hold = 1'b1;
                  end
               end else if (ld_use_stall) begin
                  pc_hold    = 1'b1;
                  stall_ifid = 1'b1;
                  flush_idex = 1'b1;
               end else if (id_jmp) begin
                  flush_ifid = 1'b1;
                  if (imem_rdy) begin
                     pc_take_jump = 1'b1;
                     pc_jmp_addr  = id_jmp_addr;
                  end else begin
                     pc_hold = 1'b1;
                  end
               end else if (id_hlt) begin
                  pc_hold    = 1'b1;
                  flush_ifid = 1'b1;
               end else begin
                  pc_hold    = ~imem_rdy;
                  stall_ifid = ~imem_rdy;
               end
            end
            WAIT_MEM: begin
               flush_idex = ex_br_taken;
               if (imem_rdy) begin
                  // A branch resolving in the release cycle supersedes the latched target.
                  pc_take_branch = ex_br_taken | pend_valid_q;
                  if (ex_br_taken) begin
                     pc_br_addr = ex_br_addr;
                  end else if (pend_valid_q) begin
                     pc_br_addr = pend_addr_q;
                  end
               end else begin
                  pc_hold    = 1'b1;
                  flush_ifid = 1'b1;
               end
            end
            DRAIN: begin
               pc_hold    = 1'b1;
               flush_ifid = 1'b1;
            end
            HALTED: begin
               pc_hold    = 1'b1;
               flush_ifid = 1'b1;
               halted     = 1'b1;
            end
            default: begin
               pc_hold = 1'b1;
            end
         endcase
         if (flush_ifid) begin
            stall_ifid = 1'b0;
         end
      end
   end

endmodule
